// File: rtl/pipe_out_arbiter_pkg.sv
// Shared constants, header layout and state encoding for the pipe-out arbiter.
package pipe_out_arbiter_pkg;

  localparam int WORD_W = 16;
  localparam int ID_W   = 4;
  localparam int SEQ_W  = 8;

  localparam logic [3:0]        HDR_MAGIC = 4'hA;
  localparam logic [ID_W-1:0]   IDLE_ID   = 4'hF;
  localparam logic [WORD_W-1:0] FILL      = 16'h0000;

  // Header field positions: {magic[15:12], id[11:8], seq[7:0]}
  localparam int HDR_MAGIC_LSB = 12;
  localparam int HDR_ID_LSB    = 8;
  localparam int HDR_SEQ_LSB   = 0;

  typedef enum logic {
    ST_ARB = 1'b0,
    ST_PAY = 1'b1
  } arb_state_t;

  function automatic logic [WORD_W-1:0] make_hdr(input logic [ID_W-1:0] id,
                                                 input logic [SEQ_W-1:0] seq);
    logic [WORD_W-1:0] h;
    h = '0;
    h[HDR_MAGIC_LSB +: 4]  = HDR_MAGIC;
    h[HDR_ID_LSB +: ID_W]  = id;
    h[HDR_SEQ_LSB +: SEQ_W] = seq;
    return h;
  endfunction

endpackage

// File: rtl/pipe_out_arbiter_if.sv
// Endpoint read port plus per-source FIFO-side signals of the pipe-out arbiter.
interface pipe_out_arbiter_if #(
  parameter int NUM_SRC = 4
);
  logic                  ep_read;
  logic [15:0]           ep_datain;
  logic [16*NUM_SRC-1:0] src_data;
  logic [NUM_SRC-1:0]    src_valid;
  logic [NUM_SRC-1:0]    src_avail;
  logic [NUM_SRC-1:0]    src_ready;
  logic [15:0]           underrun_cnt;

  // Arbiter side
  modport master (
    input  ep_read, src_data, src_valid, src_avail,
    output ep_datain, src_ready, underrun_cnt
  );

  // Endpoint / FIFO environment side
  modport slave (
    output ep_read, src_data, src_valid, src_avail,
    input  ep_datain, src_ready, underrun_cnt
  );
endinterface

// File: rtl/pipe_out_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester after ptr, wrapping modulo NUM_SRC.
module pipe_out_arbiter_rr_pick
  import pipe_out_arbiter_pkg::*;
#(
  parameter int NUM_SRC = 4
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [ID_W-1:0]    gnt_id,
  output logic               any
);

  // Scan positions ptr+1 .. ptr+NUM_SRC; the first hit wins, IDLE_ID when none.
  always_comb begin
    gnt_id = IDLE_ID;
    any    = 1'b0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (!any && req[i] && (i == ((int'(ptr) + k) % NUM_SRC))) begin
          any    = 1'b1;
          gnt_id = ID_W'(i);
        end
      end
    end
  end

endmodule

// File: rtl/pipe_out_arbiter.sv
// Shares one pipe-out endpoint among NUM_SRC word streams as fixed-length blocks:
// a header {magic, id, seq} followed by BLOCK_WORDS-1 payload words of one source.
module pipe_out_arbiter
  import pipe_out_arbiter_pkg::*;
#(
  parameter int NUM_SRC     = 4,
  parameter int BLOCK_WORDS = 256
) (
  input  logic ti_clk,
  input  logic ti_reset,
  pipe_out_arbiter_if.master bus
);

  localparam int CNT_W = (BLOCK_WORDS > 2) ? $clog2(BLOCK_WORDS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BLOCK_WORDS - 1);
  localparam logic [ID_W-1:0]  RST_PTR  = ID_W'(NUM_SRC - 1);

  arb_state_t          state;
  logic [CNT_W-1:0]    cnt;
  logic [SEQ_W-1:0]    seq;
  logic [ID_W-1:0]     rr_ptr;
  logic [ID_W-1:0]     grant_q;
  logic [WORD_W-1:0]   ep_datain_q;
  logic [15:0]         underrun_q;

  logic [ID_W-1:0]     cand_id;
  logic                cand_any;
  logic [ID_W-1:0]     cand_sel;
  logic [WORD_W-1:0]   cand_hdr;

  logic                fetch;
  logic                sel_hit;
  logic                sel_valid;
  logic [WORD_W-1:0]   sel_data;
  logic [WORD_W-1:0]   fetch_word;
  logic                underrun_hit;
  logic [NUM_SRC-1:0]  ready;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  pipe_out_arbiter_rr_pick #(
    .NUM_SRC (NUM_SRC)
  ) u_rr_pick (
    .req    (bus.src_avail),
    .ptr    (rr_ptr),
    .gnt_id (cand_id),
    .any    (cand_any)
  );

  assign cand_sel = cand_any ? cand_id : IDLE_ID;
  assign cand_hdr = make_hdr(cand_sel, seq);

  // A word is fetched when the header or any non-final payload word is consumed.
  assign fetch = bus.ep_read && !ti_reset && ((state == ST_ARB) || (cnt < LAST_CNT));

  // Select the granted source's head word; an idle grant matches no source.
  always_comb begin
    sel_hit   = 1'b0;
    sel_valid = 1'b0;
    sel_data  = FILL;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (grant_q == ID_W'(i)) begin
        sel_hit   = 1'b1;
        sel_valid = bus.src_valid[i];
        sel_data  = bus.src_data[16*i +: 16];
      end
    end
  end

  assign fetch_word   = (sel_hit && sel_valid) ? sel_data : FILL;
  assign underrun_hit = fetch && sel_hit && !sel_valid;

  // Pop strobe goes only to the granted source, and only when it has a word.
  always_comb begin
    ready = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      ready[i] = fetch && sel_valid && (grant_q == ID_W'(i));
    end
  end

  // Block sequencer: arbitrate in ARB, stream payload in PAY, all outputs registered.
  always_ff @(posedge ti_clk) begin
    if (ti_reset) begin
      state       <= ST_ARB;
      seq         <= '0;
      rr_ptr      <= RST_PTR;
      cnt         <= '0;
      underrun_q  <= '0;
      ep_datain_q <= make_hdr(IDLE_ID, '0);
      grant_q     <= IDLE_ID;
    end else begin
      if (underrun_hit) begin
        underrun_q <= sat_inc(underrun_q);
      end
      case (state)
        ST_ARB: begin
          if (!bus.ep_read) begin
            // Keep the displayed header and grant tracking the live candidate.
            grant_q     <= cand_sel;
            ep_datain_q <= cand_hdr;
          end else begin
            // Header consumed: grant_q is locked for the whole block.
            seq <= seq + 8'd1;
            if (grant_q != IDLE_ID) begin
              rr_ptr <= grant_q;
            end
            cnt         <= CNT_W'(1);
            state       <= ST_PAY;
            ep_datain_q <= fetch_word;
          end
        end
        ST_PAY: begin
          if (bus.ep_read) begin
            if (cnt < LAST_CNT) begin
              ep_datain_q <= fetch_word;
              cnt         <= cnt + CNT_W'(1);
            end else begin
              state       <= ST_ARB;
              cnt         <= '0;
              grant_q     <= cand_sel;
              ep_datain_q <= cand_hdr;
            end
          end
        end
        default: begin
          state <= ST_ARB;
        end
      endcase
    end
  end

  assign bus.ep_datain    = ep_datain_q;
  assign bus.src_ready    = ready;
  assign bus.underrun_cnt = underrun_q;

endmodule

// File: tb/tb_pipe_out_arbiter.sv
// Directed vector bench for pipe_out_arbiter with NUM_SRC=4, BLOCK_WORDS=4.
module tb_pipe_out_arbiter;

  localparam int NUM_SRC     = 4;
  localparam int BLOCK_WORDS = 4;

  logic ti_clk = 1'b0;
  logic ti_reset;

  pipe_out_arbiter_if #(.NUM_SRC(NUM_SRC)) bus ();

  pipe_out_arbiter #(
    .NUM_SRC     (NUM_SRC),
    .BLOCK_WORDS (BLOCK_WORDS)
  ) dut (
    .ti_clk   (ti_clk),
    .ti_reset (ti_reset),
    .bus      (bus)
  );

  always #5 ti_clk = ~ti_clk;

  // Source FIFOs: source i presents {i+1, 0, pop count}, advancing on each pop.
  logic [7:0]  pop_cnt [NUM_SRC] = '{default: 8'h00};
  logic [63:0] src_data_drv;

  always @(posedge ti_clk) begin
    for (int i = 0; i < NUM_SRC; i++)
      if (bus.src_ready[i]) pop_cnt[i] <= pop_cnt[i] + 8'd1;
  end

  always_comb begin
    src_data_drv = '0;
    for (int i = 0; i < NUM_SRC; i++)
      src_data_drv[16*i +: 16] = {4'(i + 1), 4'h0, pop_cnt[i]};
  end

  assign bus.src_data = src_data_drv;

  typedef struct packed {
    logic        rst;
    logic        rd;
    logic [3:0]  avail;
    logic [3:0]  valid;
    logic [15:0] dout;
    logic [3:0]  ready;
    logic [15:0] unr;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic vec_t mk(input logic r, input logic rd, input logic [3:0] av,
                              input logic [3:0] va, input logic [15:0] d,
                              input logic [3:0] rdy, input logic [15:0] u);
    vec_t v;
    v.rst = r; v.rd = rd; v.avail = av; v.valid = va;
    v.dout = d; v.ready = rdy; v.unr = u;
    return v;
  endfunction

  task automatic add(input logic r, input logic rd, input logic [3:0] av, input logic [3:0] va,
                     input logic [15:0] d, input logic [3:0] rdy, input logic [15:0] u);
    vecs.push_back(mk(r, rd, av, va, d, rdy, u));
  endtask

  // Drive at the falling edge; check the word about to be consumed at the next rising edge.
  task automatic apply(input vec_t v);
    @(negedge ti_clk);
    ti_reset      = v.rst;
    bus.ep_read   = v.rd;
    bus.src_avail = v.avail;
    bus.src_valid = v.valid;
    #1;
    n_vec++;
    if (bus.ep_datain !== v.dout) begin
      n_bad++;
      $display("FAIL vec%0d ep_datain got %h want %h", n_vec, bus.ep_datain, v.dout);
    end
    if (bus.src_ready !== v.ready) begin
      n_bad++;
      $display("FAIL vec%0d src_ready got %b want %b", n_vec, bus.src_ready, v.ready);
    end
    if (bus.underrun_cnt !== v.unr) begin
      n_bad++;
      $display("FAIL vec%0d underrun_cnt got %h want %h", n_vec, bus.underrun_cnt, v.unr);
    end
  endtask

  task automatic step(input logic r, input logic rd, input logic [3:0] av, input logic [3:0] va,
                      input logic [15:0] d, input logic [3:0] rdy, input logic [15:0] u);
    apply(mk(r, rd, av, va, d, rdy, u));
  endtask

  // Idle cycles with no read: the presented word must hold.
  task automatic gap(input logic [3:0] av, input logic [15:0] d, input logic [15:0] u);
    int n;
    n = int'($urandom_range(0, 3));
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, av, 4'hF, d, 4'h0, u);
  endtask

  initial begin
    ti_reset      = 1'b1;
    bus.ep_read   = 1'b0;
    bus.src_avail = '0;
    bus.src_valid = '0;
    repeat (2) @(negedge ti_clk);

    // Reset state; read strobe during reset must not pop.
    add(1, 1, 4'h0, 4'h0, 16'hAF00, 4'h0, 16'h0);

    // Idle blocks with continuous reads.
    add(0, 1, 4'h0, 4'h0, 16'hAF00, 4'h0, 16'h0);
    add(0, 1, 4'h0, 4'h0, 16'h0000, 4'h0, 16'h0);
    add(0, 1, 4'h0, 4'h0, 16'h0000, 4'h0, 16'h0);
    add(0, 1, 4'h0, 4'h0, 16'h0000, 4'h0, 16'h0);
    add(0, 1, 4'h0, 4'h0, 16'hAF01, 4'h0, 16'h0);
    add(0, 1, 4'h0, 4'h0, 16'h0000, 4'h0, 16'h0);
    add(0, 1, 4'h0, 4'h0, 16'h0000, 4'h0, 16'h0);
    add(0, 1, 4'h0, 4'h0, 16'h0000, 4'h0, 16'h0);
    add(1, 0, 4'hF, 4'hF, 16'hAF02, 4'h0, 16'h0);
    add(0, 0, 4'hF, 4'hF, 16'hAF00, 4'h0, 16'h0);

    // All sources available: round-robin 0,1,2,3.
    add(0, 1, 4'hF, 4'hF, 16'hA000, 4'h1, 16'h0);
    add(0, 1, 4'hF, 4'hF, 16'h1000, 4'h1, 16'h0);
    add(0, 1, 4'hF, 4'hF, 16'h1001, 4'h1, 16'h0);
    add(0, 1, 4'hF, 4'hF, 16'h1002, 4'h0, 16'h0);
    add(0, 1, 4'hF, 4'hF, 16'hA101, 4'h2, 16'h0);
    add(0, 1, 4'hF, 4'hF, 16'h2000, 4'h2, 16'h0);
    add(0, 1, 4'hF, 4'hF, 16'h2001, 4'h2, 16'h0);
    add(0, 1, 4'hF, 4'hF, 16'h2002, 4'h0, 16'h0);
    add(0, 1, 4'hF, 4'hF, 16'hA202, 4'h4, 16'h0);
    add(0, 1, 4'hF, 4'hF, 16'h3000, 4'h4, 16'h0);
    add(0, 1, 4'hF, 4'hF, 16'h3001, 4'h4, 16'h0);
    add(0, 1, 4'hF, 4'hF, 16'h3002, 4'h0, 16'h0);
    add(0, 1, 4'hF, 4'hF, 16'hA303, 4'h8, 16'h0);
    add(0, 1, 4'hF, 4'hF, 16'h4000, 4'h8, 16'h0);
    add(0, 1, 4'hF, 4'hF, 16'h4001, 4'h8, 16'h0);
    add(0, 1, 4'hF, 4'hF, 16'h4002, 4'h0, 16'h0);

    // Source 0 underruns on its second payload word.
    add(0, 1, 4'hF, 4'hF, 16'hA004, 4'h1, 16'h0);
    add(0, 1, 4'hF, 4'hE, 16'h1003, 4'h0, 16'h0);
    add(0, 1, 4'hF, 4'hF, 16'h0000, 4'h1, 16'h1);
    add(0, 1, 4'hF, 4'hF, 16'h1004, 4'h0, 16'h1);
    add(1, 0, 4'h0, 4'hF, 16'hA105, 4'h0, 16'h1);

    // Only source 2, then source 1 joins mid-block.
    add(0, 0, 4'h4, 4'hF, 16'hAF00, 4'h0, 16'h0);
    add(0, 1, 4'h4, 4'hF, 16'hA200, 4'h4, 16'h0);
    add(0, 1, 4'h6, 4'hF, 16'h3003, 4'h4, 16'h0);
    add(0, 1, 4'h6, 4'hF, 16'h3004, 4'h4, 16'h0);
    add(0, 1, 4'h6, 4'hF, 16'h3005, 4'h0, 16'h0);
    add(0, 1, 4'h6, 4'hF, 16'hA101, 4'h2, 16'h0);
    add(0, 1, 4'h6, 4'hF, 16'h2003, 4'h2, 16'h0);
    add(0, 1, 4'h6, 4'hF, 16'h2004, 4'h2, 16'h0);
    add(0, 1, 4'h6, 4'hF, 16'h2005, 4'h0, 16'h0);
    add(0, 1, 4'h6, 4'hF, 16'hA202, 4'h4, 16'h0);
    add(0, 0, 4'h6, 4'hF, 16'h3006, 4'h0, 16'h0);
    add(0, 1, 4'h6, 4'hF, 16'h3006, 4'h4, 16'h0);
    add(0, 1, 4'h6, 4'hF, 16'h3007, 4'h4, 16'h0);
    add(0, 1, 4'h6, 4'hF, 16'h3008, 4'h0, 16'h0);

    // Candidate switches to source 3 as header A103 is consumed: source 1 still pops.
    add(0, 1, 4'h8, 4'hF, 16'hA103, 4'h2, 16'h0);
    add(0, 1, 4'h8, 4'hF, 16'h2006, 4'h2, 16'h0);
    add(0, 1, 4'h8, 4'hF, 16'h2007, 4'h2, 16'h0);
    add(0, 1, 4'h8, 4'hF, 16'h2008, 4'h0, 16'h0);

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i]);

    // Gapped reads of a source-3 block, reset after two payload words.
    gap(4'h8, 16'hA304, 16'h0);
    step(0, 1, 4'h8, 4'hF, 16'hA304, 4'h8, 16'h0);
    gap(4'h8, 16'h4003, 16'h0);
    step(0, 1, 4'h8, 4'hF, 16'h4003, 4'h8, 16'h0);
    gap(4'h8, 16'h4004, 16'h0);
    step(0, 1, 4'h8, 4'hF, 16'h4004, 4'h8, 16'h0);
    gap(4'h8, 16'h4005, 16'h0);
    step(1, 1'($urandom_range(0, 1)), 4'h1, 4'hF, 16'h4005, 4'h0, 16'h0);
    step(0, 0, 4'h1, 4'hF, 16'hAF00, 4'h0, 16'h0);
    gap(4'h1, 16'hA000, 16'h0);
    step(0, 1, 4'h1, 4'hF, 16'hA000, 4'h1, 16'h0);
    gap(4'h1, 16'h1005, 16'h0);
    step(0, 1, 4'h1, 4'hF, 16'h1005, 4'h1, 16'h0);
    step(0, 1, 4'h1, 4'hF, 16'h1006, 4'h1, 16'h0);
    step(0, 1, 4'h1, 4'hF, 16'h1007, 4'h0, 16'h0);
    step(0, 0, 4'h1, 4'hF, 16'hA001, 4'h0, 16'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/pipe_out_arbiter.md
# pipe_out_arbiter

Shares one Output Pipe endpoint (0xA0–0xBF) among NUM_SRC user-side word streams. It sits between the okPipeOut instance's `ep_read`/`ep_datain` pair and the user FIFOs. It serves the host fixed-length blocks of BLOCK_WORDS 16-bit words: a header word naming the source, then payload from one source. Sources are granted round-robin at block boundaries. Host reads never stall; if no source can fill a block, an idle block is emitted.

## Interface
Parameters:
- NUM_SRC, 4: number of sources; legal range 1..15.
- BLOCK_WORDS, 256: words per block, header included; legal range 2..65536.

Ports:
- ti_clk  in  1  endpoint clock; all logic is in this domain.
- ti_reset  in  1  synchronous, active-high reset.
- ep_read  in  1  read strobe from okPipeOut; one word is consumed per cycle high.
- ep_datain  out  16  word presented to okPipeOut; registered.
- src_data  in  16*NUM_SRC  per-source word, first-word-fall-through; source i is bits [16i+15:16i].
- src_valid  in  NUM_SRC  src_data[i] holds a word.
- src_avail  in  NUM_SRC  source i holds ≥ BLOCK_WORDS−1 words (prog-full style).
- src_ready  out  NUM_SRC  pop strobe; combinational from ep_read.
- underrun_cnt  out  16  saturating count of payload words substituted with FILL.

## Operation
Header format is {HDR_MAGIC 4'hA, id[3:0], seq[7:0]}.
- id is the granted source, or IDLE_ID 4'hF for an idle block.
- seq is an 8-bit block counter. It increments (wrapping at 255→0) when each header is consumed.

States:
- ARB (reset state): ep_datain shows the header of the current candidate.
  - Candidate = first i with src_avail[i], scanning rr_ptr+1, rr_ptr+2, … modulo NUM_SRC.
  - If no source has src_avail set, the candidate is idle.
  - Every cycle without ep_read, the candidate, ep_datain and grant_q are re-registered.
- ARB with ep_read: the registered grant_q is locked; a later candidate does not override it.
  - seq increments.
  - If grant_q is real, rr_ptr ← grant_q; rr_ptr is unchanged for an idle block.
  - cnt ← 1, go to PAY.
  - ep_datain ← first payload word.
- PAY with ep_read and cnt < BLOCK_WORDS−1:
  - ep_datain ← next payload word.
  - cnt ← cnt+1.
- PAY with ep_read and cnt == BLOCK_WORDS−1: the last word is consumed.
  - Go to ARB.
  - ep_datain ← header of the candidate computed this cycle.
  - If BLOCK_WORDS = 2, the only payload word is loaded on leaving ARB. This condition then holds immediately, so no further fetch occurs.
- Payload fetch occurs when the word consumed is the header or a payload word with cnt < BLOCK_WORDS−1:
  - Real grant, src_valid[grant] = 1: word = src_data[grant]; src_ready[grant] = 1 in that cycle.
  - Real grant, src_valid[grant] = 0: word = FILL 16'h0000; underrun_cnt increments, saturating at 0xFFFF; src_ready stays 0.
  - Idle grant: word = FILL; no count; no pop.
- src_ready is never asserted without ep_read, and never for more than one source per cycle.

Boundary conditions:
- src_avail changes during a block have no effect until the next ARB.
- NUM_SRC = 1: the candidate is always source 0 when src_avail[0] is set.
- ti_reset mid-block:
  - state ← ARB, seq ← 0, rr_ptr ← NUM_SRC−1, cnt ← 0, underrun_cnt ← 0.
  - ep_datain ← 16'hAF00; grant_q ← idle.
  - src_ready = 0 during reset.
  - The host must resynchronise on HDR_MAGIC.

## Timing
- An ep_read high at edge t consumes the ep_datain value present before t. The next word appears on ep_datain after edge t, in time for back-to-back reads.
- Payload latency from source to ep_datain is 1 cycle, registered at the pop edge.
- ARB re-arbitration latency: a src_avail change at cycle t is reflected in ep_datain after edge t.
- Block length is exactly BLOCK_WORDS consumed words, regardless of underruns.

## Structure
- Shared include `pipe_out_arbiter_defs.v`, alongside parameters.v/mappings.v, holds:
  - localparams HDR_MAGIC, IDLE_ID, FILL;
  - the header field positions.
- The cnt width is defined in pipe_out_arbiter itself as clog2(BLOCK_WORDS), since BLOCK_WORDS is a per-instance parameter.
- One sub-module, `rr_pick`: a combinational round-robin priority picker.
  - Inputs: req[NUM_SRC], ptr.
  - Outputs: gnt_id, any.
- All state (state, cnt, seq, rr_ptr, grant_q, ep_datain, underrun_cnt) lives in the top level.

## Test plan
All scenarios use NUM_SRC = 4 and BLOCK_WORDS = 4.
1. Reset, no src_avail, continuous ep_read.
   - Words: AF00, 0000, 0000, 0000, AF01, …
   - src_ready stays 0.
2. All four sources avail, each with counting data; continuous read for 16 words.
   - Headers: A000, A101, A202, A303.
   - Each block carries 3 words of its own source.
   - src_ready pulses 3 times per source.
3. Only source 2 avail, then source 1 asserts avail mid-block.
   - Blocks: A200 (source 2), A101 (source 1), A202 (source 2).
4. Source 0 granted; src_valid[0] drops before the 2nd payload word.
   - That word = 0000.
   - underrun_cnt = 1.
   - Block length is still 4.
5. Candidate changes in the same cycle ep_read consumes a header.
   - The consumed header's id is the source that gets popped.
6. ti_reset asserted after 2 payload words, with ep_read gapped randomly.
   - Next word read is AF00 (or A000 if source 0 is avail).
   - seq restarts at 0.
   - Header values hold throughout the gaps.
